// File: rtl/ddsm_ctrl_pkg.sv
// Shared definitions for the DDSM fractional-word controller.
// Contents:
//   state_t  - controller FSM state encoding
//   C_FRAC_W - default fractional word width
//   C_STEP_W - default ramp step width
package ddsm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2,
    ST_RAMP = 2'd3
  } state_t;

  localparam int unsigned C_FRAC_W = 20;
  localparam int unsigned C_STEP_W = 8;

endpackage

// File: rtl/ddsm_frac_ctrl.sv
// Sequencer for the noise-coupled DDSM datapath.
// Accepts fractional-word updates from the host and applies them at sample
// ticks, either as a jump or as a slew-limited ramp. It also sequences
// modulator start-up: dither seed load, then run enable.
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_en           modulator enable request
//   i_tick         modulator sample-enable strobe
//   i_cfg_valid    host config valid      / o_cfg_ready  controller ready
//   i_cfg_frac     target fractional word / i_cfg_step   ramp step (0 = jump)
//   o_frac_word    word to modulator input
//   o_seed_load    one-cycle dither seed load pulse
//   o_mod_run      clock-enable for modulator and output stage
//   o_busy         high in SEED and RAMP
//   o_done         one-cycle pulse when o_frac_word reaches the target
//
// state | meaning
// ------+---------------------------------------------------------------
// OFF   | modulator stopped; host writes load the word directly
// SEED  | waiting for first tick to load the dither seed
// RUN   | modulator running, idle; accepting a new target
// RAMP  | moving the word toward the target, one step per tick
module ddsm_frac_ctrl
  import ddsm_ctrl_pkg::*;
#(
  parameter int unsigned P_FRAC_W = C_FRAC_W,
  parameter int unsigned P_STEP_W = C_STEP_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_tick,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [P_FRAC_W-1:0] i_cfg_frac,
  input  logic [P_STEP_W-1:0] i_cfg_step,
  output logic [P_FRAC_W-1:0] o_frac_word,
  output logic                o_seed_load,
  output logic                o_mod_run,
  output logic                o_busy,
  output logic                o_done
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [P_FRAC_W-1:0] r_frac;
  logic [P_FRAC_W-1:0] w_frac_nxt;
  logic [P_FRAC_W-1:0] r_tgt;
  logic [P_FRAC_W-1:0] w_tgt_nxt;
  logic [P_STEP_W-1:0] r_step;
  logic [P_STEP_W-1:0] w_step_nxt;
  logic                r_cfg_ready;
  logic                r_seed;
  logic                r_run;
  logic                r_busy;
  logic                r_done;
  logic                w_seed_nxt;
  logic                w_done_nxt;
  logic                w_hs;
  logic                w_up;
  logic [P_FRAC_W:0]   w_diff;
  logic [P_FRAC_W:0]   w_step_ext;

  assign w_hs       = i_cfg_valid & r_cfg_ready;
  assign w_up       = (r_tgt > r_frac);
  // One extra bit so the magnitude never wraps regardless of direction.
  assign w_diff     = w_up ? ({1'b0, r_tgt} - {1'b0, r_frac})
                           : ({1'b0, r_frac} - {1'b0, r_tgt});
  assign w_step_ext = {{(P_FRAC_W + 1 - P_STEP_W){1'b0}}, r_step};

  always_comb begin
    w_state_nxt = r_state;
    w_frac_nxt  = r_frac;
    w_tgt_nxt   = r_tgt;
    w_step_nxt  = r_step;
    w_seed_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (w_hs) w_frac_nxt = i_cfg_frac;
        if (i_en) w_state_nxt = ST_SEED;
      end
      ST_SEED: begin
        if (!i_en) begin
          w_state_nxt = ST_OFF;
        end else if (i_tick) begin
          w_state_nxt = ST_RUN;
          w_seed_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        // A tick coinciding with the handshake is ignored here; the first
        // update lands on the next tick seen in RAMP.
        if (!i_en) begin
          w_state_nxt = ST_OFF;
        end else if (w_hs) begin
          w_tgt_nxt   = i_cfg_frac;
          w_step_nxt  = i_cfg_step;
          w_state_nxt = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (!i_en) begin
          w_state_nxt = ST_OFF;
        end else if (i_tick) begin
          if ((r_step == '0) || (w_diff <= w_step_ext)) begin
            w_frac_nxt  = r_tgt;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_RUN;
          end else if (w_up) begin
            w_frac_nxt = r_frac + w_step_ext[P_FRAC_W-1:0];
          end else begin
            w_frac_nxt = r_frac - w_step_ext[P_FRAC_W-1:0];
          end
        end
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  // Status outputs are registered from the next state so they track the
  // state register exactly, while still reading 0 during reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_OFF;
      r_frac      <= '0;
      r_tgt       <= '0;
      r_step      <= '0;
      r_cfg_ready <= 1'b0;
      r_seed      <= 1'b0;
      r_run       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frac      <= w_frac_nxt;
      r_tgt       <= w_tgt_nxt;
      r_step      <= w_step_nxt;
      r_cfg_ready <= (w_state_nxt == ST_OFF) || (w_state_nxt == ST_RUN);
      r_seed      <= w_seed_nxt;
      r_run       <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_RAMP);
      r_busy      <= (w_state_nxt == ST_SEED) || (w_state_nxt == ST_RAMP);
      r_done      <= w_done_nxt;
    end
  end

  assign o_cfg_ready = r_cfg_ready;
  assign o_frac_word = r_frac;
  assign o_seed_load = r_seed;
  assign o_mod_run   = r_run;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_ddsm_frac_ctrl.sv
// Directed self-checking bench for ddsm_frac_ctrl.
module tb_ddsm_frac_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_en = 1'b0;
  logic        i_tick = 1'b0;
  logic        i_cfg_valid = 1'b0;
  logic        o_cfg_ready;
  logic [19:0] i_cfg_frac = '0;
  logic [7:0]  i_cfg_step = '0;
  logic [19:0] o_frac_word;
  logic        o_seed_load;
  logic        o_mod_run;
  logic        o_busy;
  logic        o_done;

  int npass = 0;
  int ntot  = 0;

  ddsm_frac_ctrl #(.P_FRAC_W(20), .P_STEP_W(8)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_tick      (i_tick),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_frac  (i_cfg_frac),
    .i_cfg_step  (i_cfg_step),
    .o_frac_word (o_frac_word),
    .o_seed_load (o_seed_load),
    .o_mod_run   (o_mod_run),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one active edge, then settle 1 time unit past it.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Tick every 4 cycles: three quiet cycles, then a tick edge.
  task automatic do_tick();
    repeat (3) cyc();
    i_tick = 1'b1;
    cyc();
    i_tick = 1'b0;
  endtask

  task automatic host_write(input logic [19:0] frac, input logic [7:0] step);
    i_cfg_valid = 1'b1;
    i_cfg_frac  = frac;
    i_cfg_step  = step;
    cyc();
    i_cfg_valid = 1'b0;
  endtask

  logic [19:0] up_exp [4];
  logic [19:0] dn_exp [3];

  initial begin
    up_exp[0] = 20'd30; up_exp[1] = 20'd60; up_exp[2] = 20'd90; up_exp[3] = 20'd100;
    dn_exp[0] = 20'd60; dn_exp[1] = 20'd20; dn_exp[2] = 20'd10;

    // Reset
    i_rst = 1'b1;
    cyc(); cyc();
    chk("rst_frac",  o_frac_word, 0);
    chk("rst_ready", o_cfg_ready, 0);
    chk("rst_run",   o_mod_run,   0);
    chk("rst_seed",  o_seed_load, 0);
    chk("rst_busy",  o_busy,      0);
    chk("rst_done",  o_done,      0);
    i_rst = 1'b0;
    cyc();
    chk("off_ready", o_cfg_ready, 1);

    // Start-up sequence
    i_en = 1'b1;
    cyc();
    chk("seed_busy",  o_busy,      1);
    chk("seed_ready", o_cfg_ready, 0);
    chk("seed_run",   o_mod_run,   0);
    do_tick();
    chk("start_seed",  o_seed_load, 1);
    chk("start_run",   o_mod_run,   1);
    chk("start_busy",  o_busy,      0);
    chk("start_ready", o_cfg_ready, 1);
    cyc();
    chk("seed_pulse_end", o_seed_load, 0);
    chk("run_hold",       o_mod_run,   1);

    // Upward ramp 0 -> 100, step 30
    host_write(20'd100, 8'd30);
    chk("ramp_up_ready", o_cfg_ready, 0);
    chk("ramp_up_busy",  o_busy,      1);
    chk("ramp_up_frac0", o_frac_word, 0);
    for (int i = 0; i < 4; i++) begin
      repeat (3) begin
        cyc();
        chk("ramp_up_ready_mid", o_cfg_ready, 0);
      end
      i_tick = 1'b1;
      cyc();
      i_tick = 1'b0;
      chk("ramp_up_frac", o_frac_word, up_exp[i]);
      chk("ramp_up_done", o_done, (i == 3) ? 1 : 0);
    end
    chk("ramp_up_end_ready", o_cfg_ready, 1);
    cyc();
    chk("ramp_up_done_pulse", o_done, 0);

    // Downward ramp 100 -> 10, step 40
    host_write(20'd10, 8'd40);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      chk("ramp_dn_frac", o_frac_word, dn_exp[i]);
      chk("ramp_dn_done", o_done, (i == 2) ? 1 : 0);
    end

    // Jump with step 0
    host_write(20'h12345, 8'd0);
    do_tick();
    chk("jump_frac", o_frac_word, 20'h12345);
    chk("jump_done", o_done, 1);

    // Handshake coincident with a tick in RUN: no change until next tick
    i_cfg_valid = 1'b1; i_cfg_frac = 20'h12000; i_cfg_step = 8'd0; i_tick = 1'b1;
    cyc();
    i_cfg_valid = 1'b0; i_tick = 1'b0;
    chk("coinc_frac", o_frac_word, 20'h12345);
    chk("coinc_done", o_done, 0);
    do_tick();
    chk("coinc_next_frac", o_frac_word, 20'h12000);
    chk("coinc_next_done", o_done, 1);

    // Abort mid-ramp
    host_write(20'd0, 8'd0);
    do_tick();
    chk("zero_frac", o_frac_word, 0);
    host_write(20'd100, 8'd30);
    do_tick();
    do_tick();
    chk("abort_pre_frac", o_frac_word, 60);
    i_en = 1'b0;
    cyc();
    chk("abort_run",   o_mod_run,   0);
    chk("abort_busy",  o_busy,      0);
    chk("abort_frac",  o_frac_word, 60);
    chk("abort_done",  o_done,      0);
    chk("abort_ready", o_cfg_ready, 1);
    do_tick();
    chk("abort_hold_frac", o_frac_word, 60);
    chk("abort_hold_done", o_done, 0);

    // Re-enable passes through SEED again
    i_en = 1'b1;
    cyc();
    chk("reen_busy", o_busy,    1);
    chk("reen_run",  o_mod_run, 0);
    do_tick();
    chk("reen_seed", o_seed_load, 1);
    chk("reen_run2", o_mod_run,   1);
    chk("reen_frac", o_frac_word, 60);
    cyc();
    chk("reen_seed_end", o_seed_load, 0);

    // Handshake in OFF loads directly
    i_en = 1'b0;
    cyc();
    host_write(20'hABCDE, 8'd5);
    chk("off_hs_frac", o_frac_word, 20'hABCDE);
    chk("off_hs_done", o_done, 0);
    chk("off_hs_run",  o_mod_run, 0);

    // Synchronous reset during RAMP
    i_en = 1'b1;
    cyc();
    do_tick();
    host_write(20'd0, 8'd1);
    do_tick();
    chk("pre_rst_frac", o_frac_word, 20'hABCDD);
    chk("pre_rst_busy", o_busy, 1);
    i_rst = 1'b1;
    cyc();
    chk("mid_rst_frac",  o_frac_word, 0);
    chk("mid_rst_run",   o_mod_run,   0);
    chk("mid_rst_busy",  o_busy,      0);
    chk("mid_rst_ready", o_cfg_ready, 0);
    chk("mid_rst_seed",  o_seed_load, 0);
    chk("mid_rst_done",  o_done,      0);
    i_rst = 1'b0;
    i_en  = 1'b0;
    cyc();
    chk("post_rst_ready", o_cfg_ready, 1);
    chk("post_rst_busy",  o_busy,      0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
